// File: rtl/l2_req_arbiter_if.sv
// Signal bundle around the L2 request arbiter: L1 I/D request ports, the shared
// L2 port and the per-side performance counters.
interface l2_req_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int BLK_W  = 128,
    parameter int CNT_W  = 51
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [BLK_W-1:0]  i_rdata;
    logic              i_ready;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [BLK_W-1:0]  d_wdata;
    logic [BLK_W-1:0]  d_rdata;
    logic              d_ready;
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_addr;
    logic [BLK_W-1:0]  l2_wdata;
    logic [BLK_W-1:0]  l2_rdata;
    logic              l2_ready;
    logic [CNT_W-1:0]  i_wait_cnt;
    logic [CNT_W-1:0]  d_wait_cnt;
    logic [CNT_W-1:0]  i_grant_cnt;
    logic [CNT_W-1:0]  d_grant_cnt;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_ready,
        output i_rdata, i_ready, d_rdata, d_ready, l2_read, l2_write, l2_addr, l2_wdata,
               i_wait_cnt, d_wait_cnt, i_grant_cnt, d_grant_cnt
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_ready,
        input  i_rdata, i_ready, d_rdata, d_ready, l2_read, l2_write, l2_addr, l2_wdata,
               i_wait_cnt, d_wait_cnt, i_grant_cnt, d_grant_cnt
    );
endinterface

// File: rtl/l2_req_arbiter.sv
// Shares the single L2 port between the L1 I-cache and D-cache miss paths, routes
// the L2 response back to the owner and keeps saturating wait/grant counters.
module l2_req_arbiter #(
    parameter int ADDR_W     = 28,
    parameter int BLK_W      = 128,
    parameter int CNT_W      = 51,
    parameter bit D_PRIORITY = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    l2_req_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_I  = 2'd1,
        BUSY_D  = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t            state_r, state_nxt_s;
    logic              last_d_r, last_d_nxt_s;
    logic              l2_read_r, l2_read_nxt_s;
    logic              l2_write_r, l2_write_nxt_s;
    logic [ADDR_W-1:0] l2_addr_r, l2_addr_nxt_s;
    logic [BLK_W-1:0]  l2_wdata_r, l2_wdata_nxt_s;
    logic [CNT_W-1:0]  i_wait_r, d_wait_r, i_grant_r, d_grant_r;
    logic              d_req_s, grant_i_s, grant_d_s, i_ready_s, d_ready_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
        logic [CNT_W-1:0] res;
        if (en && (cnt != {CNT_W{1'b1}})) begin
            res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Next-state, grant selection and combinational ready routing
    always_comb begin
        state_nxt_s    = state_r;
        last_d_nxt_s   = last_d_r;
        l2_read_nxt_s  = l2_read_r;
        l2_write_nxt_s = l2_write_r;
        l2_addr_nxt_s  = l2_addr_r;
        l2_wdata_nxt_s = l2_wdata_r;
        grant_i_s      = 1'b0;
        grant_d_s      = 1'b0;
        i_ready_s      = 1'b0;
        d_ready_s      = 1'b0;
        d_req_s        = bus.d_read | bus.d_write;
        case (state_r)
            IDLE: begin
                if (bus.i_read && d_req_s) begin
                    // On a tie the side that did not win last time goes next
                    if ((D_PRIORITY != 1'b0) || !last_d_r) begin
                        grant_d_s = 1'b1;
                    end else begin
                        grant_i_s = 1'b1;
                    end
                end else if (bus.i_read) begin
                    grant_i_s = 1'b1;
                end else if (d_req_s) begin
                    grant_d_s = 1'b1;
                end else begin
                    grant_i_s = 1'b0;
                    grant_d_s = 1'b0;
                end
                if (grant_d_s) begin
                    state_nxt_s    = BUSY_D;
                    last_d_nxt_s   = 1'b1;
                    l2_write_nxt_s = bus.d_write;
                    l2_read_nxt_s  = ~bus.d_write;
                    l2_addr_nxt_s  = bus.d_addr;
                    l2_wdata_nxt_s = bus.d_wdata;
                end else if (grant_i_s) begin
                    state_nxt_s    = BUSY_I;
                    last_d_nxt_s   = 1'b0;
                    l2_write_nxt_s = 1'b0;
                    l2_read_nxt_s  = 1'b1;
                    l2_addr_nxt_s  = bus.i_addr;
                    l2_wdata_nxt_s = {BLK_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY_I, BUSY_D: begin
                i_ready_s = bus.l2_ready && (state_r == BUSY_I);
                d_ready_s = bus.l2_ready && (state_r == BUSY_D);
                if (bus.l2_ready) begin
                    state_nxt_s    = RECOVER;
                    l2_read_nxt_s  = 1'b0;
                    l2_write_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            RECOVER: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s    = IDLE;
                l2_read_nxt_s  = 1'b0;
                l2_write_nxt_s = 1'b0;
            end
        endcase
    end

    // State, latched L2 request and performance counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            last_d_r   <= 1'b0;
            l2_read_r  <= 1'b0;
            l2_write_r <= 1'b0;
            l2_addr_r  <= {ADDR_W{1'b0}};
            l2_wdata_r <= {BLK_W{1'b0}};
            i_wait_r   <= {CNT_W{1'b0}};
            d_wait_r   <= {CNT_W{1'b0}};
            i_grant_r  <= {CNT_W{1'b0}};
            d_grant_r  <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            last_d_r   <= last_d_nxt_s;
            l2_read_r  <= l2_read_nxt_s;
            l2_write_r <= l2_write_nxt_s;
            l2_addr_r  <= l2_addr_nxt_s;
            l2_wdata_r <= l2_wdata_nxt_s;
            i_wait_r   <= sat_inc(i_wait_r, bus.i_read & ~i_ready_s);
            d_wait_r   <= sat_inc(d_wait_r, d_req_s & ~d_ready_s);
            i_grant_r  <= sat_inc(i_grant_r, grant_i_s);
            d_grant_r  <= sat_inc(d_grant_r, grant_d_s);
        end
    end

    assign bus.i_rdata     = bus.l2_rdata;
    assign bus.d_rdata     = bus.l2_rdata;
    assign bus.i_ready     = i_ready_s;
    assign bus.d_ready     = d_ready_s;
    assign bus.l2_read     = l2_read_r;
    assign bus.l2_write    = l2_write_r;
    assign bus.l2_addr     = l2_addr_r;
    assign bus.l2_wdata    = l2_wdata_r;
    assign bus.i_wait_cnt  = i_wait_r;
    assign bus.d_wait_cnt  = d_wait_r;
    assign bus.i_grant_cnt = i_grant_r;
    assign bus.d_grant_cnt = d_grant_r;
endmodule

// File: tb/tb_l2_req_arbiter.sv
// Bench for l2_req_arbiter: reset, directed vectors, corner sequences and a
// randomized run against a transaction-level reference model.
`timescale 1ns/1ps
module tb_l2_req_arbiter;
    localparam int ADDR_W = 28;
    localparam int BLK_W  = 128;
    localparam int CNT_W  = 51;
    localparam int CNT1_W = 4;

    typedef struct {
        bit                ir;
        bit                dr;
        bit                dw;
        logic [ADDR_W-1:0] ia;
        logic [ADDR_W-1:0] da;
        logic [BLK_W-1:0]  wd;
        int                lat;
        bit                exp_d;
        bit                exp_wr;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    l2_req_arbiter_if #(.ADDR_W(ADDR_W), .BLK_W(BLK_W), .CNT_W(CNT_W))  bus0 ();
    l2_req_arbiter_if #(.ADDR_W(ADDR_W), .BLK_W(BLK_W), .CNT_W(CNT1_W)) bus1 ();

    l2_req_arbiter #(.ADDR_W(ADDR_W), .BLK_W(BLK_W), .CNT_W(CNT_W), .D_PRIORITY(1'b0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    l2_req_arbiter #(.ADDR_W(ADDR_W), .BLK_W(BLK_W), .CNT_W(CNT1_W), .D_PRIORITY(1'b1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    task automatic check(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus0.i_read = 1'b0; bus0.i_addr = '0; bus0.d_read = 1'b0; bus0.d_write = 1'b0;
        bus0.d_addr = '0; bus0.d_wdata = '0; bus0.l2_rdata = '0; bus0.l2_ready = 1'b0;
        bus1.i_read = 1'b0; bus1.i_addr = '0; bus1.d_read = 1'b0; bus1.d_write = 1'b0;
        bus1.d_addr = '0; bus1.d_wdata = '0; bus1.l2_rdata = '0; bus1.l2_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive_pt();
        rst = 1'b1;
    endtask

    function automatic vec_t mk(input bit ir, input bit dr, input bit dw, input logic [ADDR_W-1:0] ia,
                                input logic [ADDR_W-1:0] da, input logic [BLK_W-1:0] wd, input int lat,
                                input bit exp_d, input bit exp_wr, input logic [ADDR_W-1:0] exp_addr);
        vec_t v;
        v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.wd = wd; v.lat = lat;
        v.exp_d = exp_d; v.exp_wr = exp_wr; v.exp_addr = exp_addr;
        return v;
    endfunction

    // One transaction on dut0 from IDLE: grant, hold through busy, ready pulse, recover
    task automatic apply_vec(input vec_t v, input int idx);
        logic [BLK_W-1:0] rd;
        bus0.i_read = v.ir; bus0.i_addr = v.ia;
        bus0.d_read = v.dr; bus0.d_write = v.dw; bus0.d_addr = v.da; bus0.d_wdata = v.wd;
        drive_pt();
        check($sformatf("vec%0d l2_read", idx), bus0.l2_read, !v.exp_wr);
        check($sformatf("vec%0d l2_write", idx), bus0.l2_write, v.exp_wr);
        check($sformatf("vec%0d l2_addr", idx), bus0.l2_addr, v.exp_addr);
        if (v.exp_wr) check($sformatf("vec%0d l2_wdata", idx), bus0.l2_wdata, v.wd);
        for (int c = 0; c <= v.lat; c++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            bus0.i_addr = ADDR_W'($urandom);
            bus0.d_addr = ADDR_W'($urandom);
            bus0.d_wdata = {$urandom, $urandom, $urandom, $urandom};
            bus0.l2_rdata = rd;
            bus0.l2_ready = (c == v.lat);
            @(negedge clk);
            check($sformatf("vec%0d held l2_addr c%0d", idx, c), bus0.l2_addr, v.exp_addr);
            check($sformatf("vec%0d held l2_write c%0d", idx, c), bus0.l2_write, v.exp_wr);
            check($sformatf("vec%0d i_ready c%0d", idx, c), bus0.i_ready, (c == v.lat) && !v.exp_d);
            check($sformatf("vec%0d d_ready c%0d", idx, c), bus0.d_ready, (c == v.lat) && v.exp_d);
            if (c == v.lat) begin
                if (v.exp_d) check($sformatf("vec%0d d_rdata", idx), bus0.d_rdata, rd);
                else check($sformatf("vec%0d i_rdata", idx), bus0.i_rdata, rd);
            end
            drive_pt();
        end
        bus0.l2_ready = 1'b0; bus0.i_read = 1'b0; bus0.d_read = 1'b0; bus0.d_write = 1'b0;
        @(negedge clk);
        check($sformatf("vec%0d recover l2 op", idx), {bus0.l2_read, bus0.l2_write}, 2'b00);
        drive_pt();
    endtask

    // Randomized run on dut0 against a transaction-level model of the arbitration rules
    task automatic run_random(input int ncyc);
        int               m_owner = 0;   // 0 none, 1 I, 2 D
        int               m_last = 1;
        int               pick;
        bit               m_gap = 1'b0;  // post-transaction dead cycle pending
        bit               m_wr = 1'b0;
        logic [ADDR_W-1:0] m_addr = '0;
        logic [BLK_W-1:0]  m_wdata = '0;
        logic [CNT_W-1:0]  m_iw = '0, m_dw = '0, m_ig = '0, m_dg = '0;
        bit               i_on = 1'b0, d_on = 1'b0, i_done = 1'b0, d_done = 1'b0, armed = 1'b0;
        bit               exp_ir, exp_dr, i_req, d_req;
        int               lat = 0;
        int               op;
        logic [BLK_W-1:0]  rd;
        for (int n = 0; n < ncyc; n++) begin
            if (!i_on) begin
                if ($urandom_range(0, 2) == 0) begin
                    i_on = 1'b1;
                    bus0.i_addr = ADDR_W'($urandom);
                end
            end else if (i_done) begin
                i_on = 1'b0;
            end else begin
                i_on = 1'b1;
            end
            bus0.i_read = i_on;
            if (!d_on) begin
                if ($urandom_range(0, 2) == 0) begin
                    d_on = 1'b1;
                    op = $urandom_range(0, 2);
                    bus0.d_read = (op != 1);
                    bus0.d_write = (op != 0);
                    bus0.d_addr = ADDR_W'($urandom);
                    bus0.d_wdata = {$urandom, $urandom, $urandom, $urandom};
                end
            end else if (d_done) begin
                d_on = 1'b0;
                bus0.d_read = 1'b0;
                bus0.d_write = 1'b0;
            end
            rd = {$urandom, $urandom, $urandom, $urandom};
            bus0.l2_rdata = rd;
            if (bus0.l2_read || bus0.l2_write) begin
                if (!armed) begin
                    lat = $urandom_range(0, 3);
                    armed = 1'b1;
                end
                if (lat == 0) begin
                    bus0.l2_ready = 1'b1;
                    armed = 1'b0;
                end else begin
                    bus0.l2_ready = 1'b0;
                    lat--;
                end
            end else begin
                bus0.l2_ready = ($urandom_range(0, 9) == 0);
                armed = 1'b0;
            end
            @(negedge clk);
            exp_ir = (m_owner == 1) && bus0.l2_ready;
            exp_dr = (m_owner == 2) && bus0.l2_ready;
            check("rnd i_ready", bus0.i_ready, exp_ir);
            check("rnd d_ready", bus0.d_ready, exp_dr);
            if (exp_ir) check("rnd i_rdata", bus0.i_rdata, rd);
            if (exp_dr) check("rnd d_rdata", bus0.d_rdata, rd);
            check("rnd l2_read", bus0.l2_read, (m_owner != 0) && !m_wr);
            check("rnd l2_write", bus0.l2_write, (m_owner != 0) && m_wr);
            if (m_owner != 0) check("rnd l2_addr", bus0.l2_addr, m_addr);
            if ((m_owner != 0) && m_wr) check("rnd l2_wdata", bus0.l2_wdata, m_wdata);
            if ((n % 32) == 31) begin
                check("rnd i_wait_cnt", bus0.i_wait_cnt, m_iw);
                check("rnd d_wait_cnt", bus0.d_wait_cnt, m_dw);
                check("rnd i_grant_cnt", bus0.i_grant_cnt, m_ig);
                check("rnd d_grant_cnt", bus0.d_grant_cnt, m_dg);
            end
            i_req = bus0.i_read;
            d_req = bus0.d_read | bus0.d_write;
            if (i_req && !exp_ir) m_iw = m_iw + 1'b1;
            if (d_req && !exp_dr) m_dw = m_dw + 1'b1;
            if (m_owner != 0) begin
                if (bus0.l2_ready) begin
                    m_owner = 0;
                    m_gap = 1'b1;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (i_req || d_req) begin
                if (i_req && d_req) pick = (m_last == 1) ? 2 : 1;
                else pick = i_req ? 1 : 2;
                m_owner = pick;
                m_last = pick;
                m_wr = (pick == 2) && bus0.d_write;
                m_addr = (pick == 2) ? bus0.d_addr : bus0.i_addr;
                m_wdata = bus0.d_wdata;
                if (pick == 1) m_ig = m_ig + 1'b1;
                else m_dg = m_dg + 1'b1;
            end
            i_done = exp_ir;
            d_done = exp_dr;
            drive_pt();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t             vecs[8];
        int               i_pulses;
        logic [BLK_W-1:0] blk_a;

        vecs[0] = mk(1, 1, 0, 28'h0AAAAAA, 28'h0BBBBBB, 128'h0, 2, 1, 0, 28'h0BBBBBB);
        vecs[1] = mk(1, 1, 0, 28'h0AAAAAA, 28'h0BBBBBB, 128'h0, 1, 0, 0, 28'h0AAAAAA);
        vecs[2] = mk(1, 1, 0, 28'h0AAAAAA, 28'h0BBBBBB, 128'h0, 0, 1, 0, 28'h0BBBBBB);
        vecs[3] = mk(0, 1, 1, 28'h0000001, 28'h0C0FFEE,
                     128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 3, 1, 1, 28'h0C0FFEE);
        vecs[4] = mk(1, 0, 0, 28'h0FFFFFF, 28'h0000002, 128'h0, 1, 0, 0, 28'h0FFFFFF);
        vecs[5] = mk(0, 0, 1, 28'h0000003, 28'h0000000, {4{32'h55555555}}, 0, 1, 1, 28'h0000000);
        vecs[6] = mk(1, 0, 1, 28'h1234567, 28'h7654321, {4{32'hAAAAAAAA}}, 2, 0, 0, 28'h1234567);
        vecs[7] = mk(0, 1, 0, 28'h0000004, 28'hFFFFFFF, 128'h0, 2, 1, 0, 28'hFFFFFFF);

        // Reset held with ready and both requests asserted
        rst = 1'b1;
        idle_inputs();
        #1;
        rst = 1'b0;
        bus0.i_read = 1'b1; bus0.d_read = 1'b1; bus0.d_write = 1'b1; bus0.l2_ready = 1'b1;
        bus1.i_read = 1'b1; bus1.d_read = 1'b1; bus1.l2_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst l2 op", {bus0.l2_read, bus0.l2_write}, 2'b00);
            check("rst l2_addr", bus0.l2_addr, '0);
            check("rst l2_wdata", bus0.l2_wdata, '0);
            check("rst readies", {bus0.i_ready, bus0.d_ready, bus1.i_ready, bus1.d_ready}, 4'b0000);
            check("rst counters", {bus0.i_wait_cnt, bus0.d_wait_cnt, bus0.i_grant_cnt, bus0.d_grant_cnt}, '0);
            check("rst dut1 l2 op", {bus1.l2_read, bus1.l2_write}, 2'b00);
        end
        drive_pt();
        idle_inputs();
        rst = 1'b1;
        drive_pt();

        // Single I read, L2 answers three cycles after l2_read rises
        blk_a = 128'h0000000300000002_0000000100000000;
        i_pulses = 0;
        for (int c = 0; c < 7; c++) begin
            bus0.i_read = (c <= 4);
            bus0.i_addr = 28'h0000123;
            bus0.l2_ready = (c == 4);
            bus0.l2_rdata = blk_a;
            @(negedge clk);
            if (bus0.i_ready) i_pulses++;
            if (c == 0) check("seqA l2_read before grant", bus0.l2_read, 1'b0);
            if (c == 1) check("seqA l2_read after grant", bus0.l2_read, 1'b1);
            if (c == 1) check("seqA l2_addr", bus0.l2_addr, 28'h0000123);
            if (c == 4) check("seqA i_rdata", bus0.i_rdata, blk_a);
            if (c == 4) check("seqA i_ready", bus0.i_ready, 1'b1);
            drive_pt();
        end
        check("seqA i_ready pulses", i_pulses, 1);
        check("seqA i_wait_cnt", bus0.i_wait_cnt, 4);
        check("seqA i_grant_cnt", bus0.i_grant_cnt, 1);
        check("seqA d_grant_cnt", bus0.d_grant_cnt, 0);

        // Directed vectors from a fresh reset: tie rotation, write priority, held address
        do_reset();
        for (int k = 0; k < 8; k++) begin
            apply_vec(vecs[k], k);
            if (k == 2) begin
                check("tie d_grant_cnt", bus0.d_grant_cnt, 2);
                check("tie i_grant_cnt", bus0.i_grant_cnt, 1);
            end
        end

        // Asynchronous reset while BUSY_I, late l2_ready after release
        bus0.i_read = 1'b1; bus0.i_addr = 28'h0ABCDEF;
        drive_pt();
        check("rstmid l2_read busy", bus0.l2_read, 1'b1);
        #2;
        rst = 1'b0;
        bus0.i_read = 1'b0;
        #1;
        check("rstmid l2_read async drop", bus0.l2_read, 1'b0);
        drive_pt();
        rst = 1'b1;
        drive_pt();
        bus0.l2_ready = 1'b1;
        bus0.l2_rdata = {4{32'h0BADF00D}};
        @(negedge clk);
        check("rstmid readies", {bus0.i_ready, bus0.d_ready}, 2'b00);
        check("rstmid l2 op", {bus0.l2_read, bus0.l2_write}, 2'b00);
        drive_pt();
        bus0.l2_ready = 1'b0;
        @(negedge clk);
        check("rstmid l2 op idle", {bus0.l2_read, bus0.l2_write}, 2'b00);
        check("rstmid counters", {bus0.i_wait_cnt, bus0.d_wait_cnt, bus0.i_grant_cnt, bus0.d_grant_cnt}, '0);
        drive_pt();

        // D priority: three back-to-back D wins over a held I request, I waits to saturation
        bus1.i_read = 1'b1; bus1.i_addr = 28'h0000111;
        bus1.d_read = 1'b1; bus1.d_addr = 28'h0000222;
        for (int k = 0; k < 3; k++) begin
            drive_pt();
            check($sformatf("prio k%0d l2_addr", k), bus1.l2_addr, 28'h0000222);
            check($sformatf("prio k%0d l2_read", k), bus1.l2_read, 1'b1);
            for (int c = 0; c < 4; c++) begin
                bus1.l2_ready = (c == 3);
                @(negedge clk);
                check($sformatf("prio k%0d d_ready c%0d", k, c), bus1.d_ready, (c == 3));
                check($sformatf("prio k%0d i_ready c%0d", k, c), bus1.i_ready, 1'b0);
                if (c < 3) drive_pt();
            end
            drive_pt();
            bus1.l2_ready = 1'b0;
            bus1.d_read = 1'b0;
            @(negedge clk);
            check($sformatf("prio k%0d recover", k), bus1.l2_read, 1'b0);
            drive_pt();
            bus1.d_read = (k < 2);
        end
        drive_pt();
        check("prio I granted after D idle", bus1.l2_addr, 28'h0000111);
        bus1.l2_ready = 1'b1;
        @(negedge clk);
        check("prio i_ready", bus1.i_ready, 1'b1);
        drive_pt();
        bus1.l2_ready = 1'b0;
        bus1.i_read = 1'b0;
        drive_pt();
        check("prio d_grant_cnt", bus1.d_grant_cnt, 3);
        check("prio i_grant_cnt", bus1.i_grant_cnt, 1);
        check("prio i_wait_cnt saturated", bus1.i_wait_cnt, 4'hF);
        check("prio d_wait_cnt", bus1.d_wait_cnt, 12);

        // Randomized traffic against the reference model
        do_reset();
        run_random(1500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
